// File: rtl/switch_input_conditioner.sv
// switch_input_conditioner
//   Front-end for the 8-to-3 priority encoder / seven-segment stage.
//   Synchronises the slide switches and push-button to clk, debounces them
//   on a prescaled sample tick, presents the stable switch value on x,
//   toggles en once per debounced button press, and pulses x_chg for one
//   cycle whenever x takes a new value.
//
// Ports
//   clk    in   1  system clock, rising edge
//   rst    in   1  asynchronous active-low reset
//   sw     in   8  raw switch levels (asynchronous)
//   btn    in   1  raw push-button, 1 = pressed (asynchronous)
//   x      out  8  debounced switch value (registered)
//   en     out  1  enable toggle (registered)
//   x_chg  out  1  one-cycle pulse in the cycle x first shows a new value
module switch_input_conditioner #(
    parameter int   TICK_DIV     = 50000,
    parameter int   STABLE_TICKS = 4,
    parameter logic EN_INIT      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn,
    output logic [7:0] x,
    output logic       en,
    output logic       x_chg
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    // count+1 == STABLE_TICKS is the same as count == STABLE_TICKS-1
    localparam logic [3:0]     CNT_LAST  = 4'(STABLE_TICKS - 1);
    localparam int             BTN_CH    = 8;

    typedef enum logic {
        BTN_RELEASED = 1'b0,
        BTN_PRESSED  = 1'b1
    } btn_state_t;

    // two-flop synchronisers, channel 8 is the button
    logic [8:0]       meta_r;
    logic [8:0]       sync_r;

    logic [PW-1:0]    presc_r;
    logic [PW-1:0]    presc_nxt_s;
    logic             tick_s;

    logic [8:0]       stable_r;
    logic [8:0]       stable_nxt_s;
    logic [8:0][3:0]  cnt_r;
    logic [8:0][3:0]  cnt_nxt_s;

    btn_state_t       state_r;
    btn_state_t       state_nxt_s;
    logic             en_r;
    logic             en_nxt_s;
    logic             x_chg_r;
    logic             x_chg_nxt_s;

    // Synchroniser chain for all nine raw inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 9'd0;
            sync_r <= 9'd0;
        end else begin
            meta_r <= {btn, sw};
            sync_r <= meta_r;
        end
    end

    // Sample tick: high during the last prescaler count before wrap.
    always_comb begin
        tick_s      = 1'b0;
        presc_nxt_s = presc_r;
        if (presc_r == PRESC_MAX) begin
            tick_s      = 1'b1;
            presc_nxt_s = {PW{1'b0}};
        end else begin
            tick_s      = 1'b0;
            presc_nxt_s = presc_r + PW'(1);
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_nxt_s;
        end
    end

    // Per-channel debounce: accept a new level after enough consecutive
    // disagreeing ticks; any agreeing tick restarts the run.
    always_comb begin
        stable_nxt_s = stable_r;
        cnt_nxt_s    = cnt_r;
        if (tick_s) begin
            for (int i = 0; i < 9; i++) begin
                if (sync_r[i] == stable_r[i]) begin
                    cnt_nxt_s[i] = 4'd0;
                end else if (cnt_r[i] == CNT_LAST) begin
                    stable_nxt_s[i] = sync_r[i];
                    cnt_nxt_s[i]    = 4'd0;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + 4'd1;
                end
            end
        end else begin
            stable_nxt_s = stable_r;
            cnt_nxt_s    = cnt_r;
        end
    end

    // Change flag for the switch channels, aligned with the x update.
    always_comb begin
        x_chg_nxt_s = 1'b0;
        if (stable_nxt_s[7:0] != stable_r[7:0]) begin
            x_chg_nxt_s = 1'b1;
        end else begin
            x_chg_nxt_s = 1'b0;
        end
    end

    // Button FSM follows the debounced level that is about to be
    // registered, so the en toggle lands on the same edge as acceptance.
    always_comb begin
        state_nxt_s = state_r;
        en_nxt_s    = en_r;
        case (state_r)
            BTN_RELEASED: begin
                if (stable_nxt_s[BTN_CH]) begin
                    state_nxt_s = BTN_PRESSED;
                    en_nxt_s    = ~en_r;
                end else begin
                    state_nxt_s = BTN_RELEASED;
                end
            end
            BTN_PRESSED: begin
                if (!stable_nxt_s[BTN_CH]) begin
                    state_nxt_s = BTN_RELEASED;
                end else begin
                    state_nxt_s = BTN_PRESSED;
                end
            end
            default: begin
                state_nxt_s = BTN_RELEASED;
                en_nxt_s    = en_r;
            end
        endcase
    end

    // Debounce state, button FSM and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_r <= 9'd0;
            cnt_r    <= '{default: 4'd0};
            state_r  <= BTN_RELEASED;
            en_r     <= EN_INIT;
            x_chg_r  <= 1'b0;
        end else begin
            stable_r <= stable_nxt_s;
            cnt_r    <= cnt_nxt_s;
            state_r  <= state_nxt_s;
            en_r     <= en_nxt_s;
            x_chg_r  <= x_chg_nxt_s;
        end
    end

    assign x     = stable_r[7:0];
    assign en    = en_r;
    assign x_chg = x_chg_r;

endmodule

// File: tb/tb_switch_input_conditioner.sv
module tb_switch_input_conditioner;

    localparam int   TD  = 4;
    localparam int   ST  = 3;
    localparam logic ENI = 1'b0;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic       btn;
    logic [7:0] x;
    logic       en;
    logic       x_chg;

    int tests;
    int fails;

    // reference model state
    int         n_edges;
    logic [8:0] samp_q[$];
    logic [8:0] acc;
    int         run[9];
    logic       exp_en;
    logic       exp_chg;

    switch_input_conditioner #(
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST),
        .EN_INIT     (ENI)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .btn  (btn),
        .x    (x),
        .en   (en),
        .x_chg(x_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        n_edges = 0;
        samp_q.delete();
        acc     = 9'd0;
        for (int c = 0; c < 9; c++) run[c] = 0;
        exp_en  = ENI;
        exp_chg = 1'b0;
    endtask

    // One rising edge of the behavioural model: inputs reach the debouncer
    // two edges after being sampled; on every TD-th edge since reset each
    // channel counts consecutive disagreements and accepts at ST.
    task automatic model_edge();
        logic [8:0] used;
        logic [7:0] oldx;
        logic       oldb;
        if (!rst) begin
            model_reset();
            return;
        end
        oldx = acc[7:0];
        oldb = acc[8];
        n_edges++;
        used = (samp_q.size() >= 2) ? samp_q[samp_q.size() - 2] : 9'd0;
        samp_q.push_back({btn, sw});
        if (samp_q.size() > 2) void'(samp_q.pop_front());
        if (n_edges % TD == 0) begin
            for (int c = 0; c < 9; c++) begin
                if (used[c] != acc[c]) begin
                    run[c]++;
                    if (run[c] == ST) begin
                        acc[c] = used[c];
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
        exp_chg = (acc[7:0] != oldx);
        if (!oldb && acc[8]) exp_en = ~exp_en;
    endtask

    // Advance one clock and compare all outputs against the model.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("x", {24'd0, x}, {24'd0, acc[7:0]});
        check("en", {31'd0, en}, {31'd0, exp_en});
        check("x_chg", {31'd0, x_chg}, {31'd0, exp_chg});
    endtask

    initial begin
        int lat;
        int chg_cnt;
        int tog_cnt;
        logic prev_en;
        logic stay_ok;

        tests = 0;
        fails = 0;
        rst   = 1'b0;
        sw    = 8'h00;
        btn   = 1'b0;
        model_reset();

        // reset state
        #1;
        check("rst_x", {24'd0, x}, 32'h0);
        check("rst_en", {31'd0, en}, {31'd0, ENI});
        check("rst_chg", {31'd0, x_chg}, 32'h0);
        cyc();
        cyc();
        rst = 1'b1;

        // idle 50 cycles
        chg_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            cyc();
            chg_cnt += int'(x_chg);
        end
        check("idle_x", {24'd0, x}, 32'h0);
        check("idle_chg_cnt", chg_cnt, 0);

        // clean step to 8'h81
        sw = 8'h81;
        lat = 0;
        chg_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            chg_cnt += int'(x_chg);
            if (lat == 0 && x == 8'h81) lat = k;
        end
        check("step_x", {24'd0, x}, 32'h81);
        check("step_lat_lo", {31'd0, lat > 10}, 32'h1);
        check("step_lat_hi", {31'd0, lat <= 15}, 32'h1);
        check("step_chg_once", chg_cnt, 1);

        // 6-cycle glitch must be rejected
        sw = 8'h80;
        stay_ok = 1'b1;
        chg_cnt = 0;
        for (int k = 0; k < 36; k++) begin
            if (k == 6) sw = 8'h81;
            cyc();
            chg_cnt += int'(x_chg);
            if (x != 8'h81) stay_ok = 1'b0;
        end
        check("glitch_hold", {31'd0, stay_ok}, 32'h1);
        check("glitch_chg", chg_cnt, 0);

        // bouncing button then hold and release: one toggle
        prev_en = en;
        tog_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            btn = (b % 2 == 0);
            for (int k = 0; k < 2; k++) begin
                cyc();
                if (en != prev_en) tog_cnt++;
                prev_en = en;
            end
        end
        btn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (en != prev_en) tog_cnt++;
            prev_en = en;
        end
        check("bounce_en_hold", {31'd0, en}, 32'h1);
        btn = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (en != prev_en) tog_cnt++;
            prev_en = en;
        end
        check("bounce_en_rel", {31'd0, en}, 32'h1);
        check("bounce_toggles", tog_cnt, 1);

        // one press brings en back to 0, then two clean presses 0->1->0
        for (int p = 0; p < 3; p++) begin
            btn = 1'b1;
            for (int k = 0; k < 30; k++) cyc();
            btn = 1'b0;
            for (int k = 0; k < 30; k++) cyc();
            if (p == 0) check("press0_en", {31'd0, en}, 32'h0);
            if (p == 1) check("press1_en", {31'd0, en}, 32'h1);
            if (p == 2) check("press2_en", {31'd0, en}, 32'h0);
        end

        // step to 8'hFF, reset mid-debounce
        sw = 8'hFF;
        for (int k = 0; k < 6; k++) cyc();
        rst = 1'b0;
        #1;
        model_reset();
        check("async_x", {24'd0, x}, 32'h0);
        check("async_en", {31'd0, en}, {31'd0, ENI});
        check("async_chg", {31'd0, x_chg}, 32'h0);
        cyc();
        rst = 1'b1;
        lat = 0;
        chg_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chg_cnt += int'(x_chg);
            if (lat == 0 && x == 8'hFF) lat = k;
        end
        check("post_rst_lat", {31'd0, (lat > 0) && (lat <= 15)}, 32'h1);
        check("post_rst_chg", chg_cnt, 1);

        // randomized segments checked cycle by cycle against the model
        for (int s = 0; s < 60; s++) begin
            int hold;
            sw   = 8'($urandom);
            btn  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 24);
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 7) == 0) sw[$urandom_range(0, 7)] ^= 1'b1;
                cyc();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
